reg_writeback: RTL and testbench

- Write-side front end for the 8x6 register file: accepts execute-stage results over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains the FIFO one entry per cycle onto the register file write port (opcode, RDAddress, RDContents).
- Exports a per-register pending scoreboard so the issue/read side can detect read-after-write hazards on queued results.

---
 rtl/reg_writeback.sv | 148 ++++++++++++++
 tb/tb_reg_writeback.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reg_writeback                                                 |
// | Purpose  : In-order write-back FIFO feeding the register file write      |
// |            port, with a per-register pending-write scoreboard.           |
// | Options  : WB_FWD_EN adds youngest-entry forwarding for both queries.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module reg_writeback #(
  parameter int M     = 3,
  parameter int N     = 6,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [M-1:0]             in_opcode,
  input  logic [M-1:0]             in_dest,
  input  logic [N-1:0]             in_result,
  input  logic                     wb_stall,
  output logic [M-1:0]             wb_opcode,
  output logic [M-1:0]             wb_addr,
  output logic [N-1:0]             wb_data,
  input  logic [M-1:0]             qa_addr,
  input  logic [M-1:0]             qb_addr,
  output logic                     hazard_a,
  output logic                     hazard_b,
  output logic [(1<<M)-1:0]        pending,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef WB_FWD_EN
  ,
  output logic                     fwd_a_valid,
  output logic [N-1:0]             fwd_a_data,
  output logic                     fwd_b_valid,
  output logic [N-1:0]             fwd_b_data
`endif
);

  localparam int AW   = $clog2(DEPTH);
  localparam int OW   = AW + 1;
  localparam int NREG = 1 << M;

  logic [M-1:0]    r_op   [DEPTH];
  logic [M-1:0]    r_dest [DEPTH];
  logic [N-1:0]    r_data [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [OW-1:0]   r_count;

  logic            w_writeable;
  logic            w_push;
  logic            w_pop;
  logic [AW-1:0]   w_ofs   [DEPTH];
  logic [DEPTH-1:0] w_valid;
  logic [NREG-1:0] w_pending;

  // Opcodes 1..4 are the only ones that update the register file.
  assign w_writeable = (in_opcode != '0) && (in_opcode <= M'(4));
  assign in_ready    = (r_count < OW'(DEPTH));
  assign w_push      = in_valid && in_ready && w_writeable;
  assign w_pop       = (r_count != '0) && !wb_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_op[i]   <= '0;
        r_dest[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_op[r_tail]   <= in_opcode;
        r_dest[r_tail] <= in_dest;
        r_data[r_tail] <= in_result;
        r_tail         <= r_tail + AW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + OW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - OW'(1);
      end
    end
  end

  assign occupancy = r_count;
  assign wb_opcode = w_pop ? r_op[r_head]   : '0;
  assign wb_addr   = w_pop ? r_dest[r_head] : '0;
  assign wb_data   = w_pop ? r_data[r_head] : '0;

  // A slot is live when its distance from the head is below the fill level.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
      assign w_ofs[i]   = AW'(i) - r_head;
      assign w_valid[i] = ({1'b0, w_ofs[i]} < r_count);
    end
  endgenerate

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i]) begin
        w_pending[r_dest[i]] = 1'b1;
      end
    end
  end

  assign pending  = w_pending;
  assign hazard_a = w_pending[qa_addr];
  assign hazard_b = w_pending[qb_addr];

`ifdef WB_FWD_EN
  logic [AW-1:0] w_age_idx [DEPTH];
  logic [N-1:0]  w_fwd_a;
  logic [N-1:0]  w_fwd_b;

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_age
      assign w_age_idx[k] = r_head + AW'(k);
    end
  endgenerate

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (OW'(k) < r_count) begin
        if (r_dest[w_age_idx[k]] == qa_addr) w_fwd_a = r_data[w_age_idx[k]];
        if (r_dest[w_age_idx[k]] == qb_addr) w_fwd_b = r_data[w_age_idx[k]];
      end
    end
  end

  assign fwd_a_valid = hazard_a;
  assign fwd_a_data  = w_fwd_a;
  assign fwd_b_valid = hazard_b;
  assign fwd_b_data  = w_fwd_b;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_reg_writeback                                              |
// | Purpose  : Self-checking bench for reg_writeback against a queue model.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_reg_writeback;

  localparam int M     = 3;
  localparam int N     = 6;
  localparam int DEPTH = 4;
  localparam int NREG  = 1 << M;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [M-1:0]           in_opcode = '0;
  logic [M-1:0]           in_dest = '0;
  logic [N-1:0]           in_result = '0;
  logic                   wb_stall = 1'b0;
  logic [M-1:0]           wb_opcode;
  logic [M-1:0]           wb_addr;
  logic [N-1:0]           wb_data;
  logic [M-1:0]           qa_addr = '0;
  logic [M-1:0]           qb_addr = '0;
  logic                   hazard_a;
  logic                   hazard_b;
  logic [NREG-1:0]        pending;
  logic [$clog2(DEPTH):0] occupancy;
`ifdef WB_FWD_EN
  logic                   fwd_a_valid;
  logic [N-1:0]           fwd_a_data;
  logic                   fwd_b_valid;
  logic [N-1:0]           fwd_b_data;
`endif

  reg_writeback #(.M(M), .N(N), .DEPTH(DEPTH)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_dest   (in_dest),
    .in_result (in_result),
    .wb_stall  (wb_stall),
    .wb_opcode (wb_opcode),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .qa_addr   (qa_addr),
    .qb_addr   (qb_addr),
    .hazard_a  (hazard_a),
    .hazard_b  (hazard_b),
    .pending   (pending),
    .occupancy (occupancy)
`ifdef WB_FWD_EN
    ,
    .fwd_a_valid (fwd_a_valid),
    .fwd_a_data  (fwd_a_data),
    .fwd_b_valid (fwd_b_valid),
    .fwd_b_data  (fwd_b_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [M-1:0] op;
    logic [M-1:0] dest;
    logic [N-1:0] data;
  } ent_t;

  ent_t q[$];   // queued writes, oldest first
  ent_t wq[$];  // writes still owed to the register file
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit writes_reg(input logic [M-1:0] op);
    return (op >= 1) && (op <= 4);
  endfunction

  task automatic check_outputs();
    logic [NREG-1:0] p  = '0;
    logic [N-1:0]    fa = '0;
    logic [N-1:0]    fb = '0;
    ent_t            h  = '0;
    foreach (q[i]) begin
      p[q[i].dest] = 1'b1;
      if (q[i].dest == qa_addr) fa = q[i].data;
      if (q[i].dest == qb_addr) fb = q[i].data;
    end
    if (q.size() > 0 && !wb_stall) h = q[0];
    check("in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
    check("occupancy", 32'(occupancy), 32'(q.size()));
    check("wb_opcode", 32'(wb_opcode), 32'(h.op));
    check("wb_addr",   32'(wb_addr),   32'(h.dest));
    check("wb_data",   32'(wb_data),   32'(h.data));
    check("pending",   32'(pending),   32'(p));
    check("hazard_a",  32'(hazard_a),  32'(p[qa_addr]));
    check("hazard_b",  32'(hazard_b),  32'(p[qb_addr]));
`ifdef WB_FWD_EN
    check("fwd_a_valid", 32'(fwd_a_valid), 32'(p[qa_addr]));
    check("fwd_a_data",  32'(fwd_a_data),  32'(fa));
    check("fwd_b_valid", 32'(fwd_b_valid), 32'(p[qb_addr]));
    check("fwd_b_data",  32'(fwd_b_data),  32'(fb));
`endif
    if (wb_opcode != '0) begin
      if (wq.size() == 0) begin
        check("wb_unexpected", 32'(wb_opcode), 32'd0);
      end else begin
        check("wb_order", 32'({wb_opcode, wb_addr, wb_data}), 32'(wq[0]));
        void'(wq.pop_front());
      end
    end
  endtask

  task automatic update_model();
    int sz  = q.size();
    bit acc = in_valid && (sz < DEPTH);
    ent_t e;
    if (sz > 0 && !wb_stall) void'(q.pop_front());
    if (acc && writes_reg(in_opcode)) begin
      e = '{op: in_opcode, dest: in_dest, data: in_result};
      q.push_back(e);
      wq.push_back(e);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic drive(input logic v, input logic [M-1:0] op, input logic [M-1:0] d,
                       input logic [N-1:0] r, input logic s);
    in_valid  = v;
    in_opcode = op;
    in_dest   = d;
    in_result = r;
    wb_stall  = s;
    step();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;

    // Single write: presented one cycle after acceptance.
    drive(1'b1, 3'd1, 3'd3, 6'h2A, 1'b0);
    repeat (3) drive(1'b0, 3'd0, 3'd0, 6'h00, 1'b0);

    // Fill under stall, then drain in order.
    for (int i = 1; i <= 4; i++) drive(1'b1, 3'd1, 3'(i), 6'(i * 7), 1'b1);
    check("full_occ",     32'(occupancy), 32'd4);
    check("full_pending", 32'(pending),   32'h1E);
    check("full_ready",   32'(in_ready),  32'd0);
    drive(1'b1, 3'd2, 3'd7, 6'h11, 1'b1);
    repeat (5) drive(1'b0, 3'd0, 3'd0, 6'h00, 1'b0);

    // Non-writing opcode is dropped.
    drive(1'b1, 3'd6, 3'd5, 6'h15, 1'b0);
    drive(1'b0, 3'd0, 3'd0, 6'h00, 1'b0);
    check("drop_pending5", 32'(pending[5]), 32'd0);

    // Same destination twice: youngest forwarded, oldest written first.
    qa_addr = 3'd2;
    qb_addr = 3'd0;
    drive(1'b1, 3'd1, 3'd2, 6'h05, 1'b1);
    drive(1'b1, 3'd4, 3'd2, 6'h3F, 1'b1);
    check("dup_hazard_a", 32'(hazard_a), 32'd1);
`ifdef WB_FWD_EN
    check("dup_fwd_a", 32'(fwd_a_data), 32'h3F);
`endif
    drive(1'b0, 3'd0, 3'd0, 6'h00, 1'b1);
    repeat (3) drive(1'b0, 3'd0, 3'd0, 6'h00, 1'b0);

    // Streaming: pointers wrap with occupancy held at one.
    for (int i = 0; i < 10; i++) drive(1'b1, 3'd2, 3'(i), 6'($urandom), 1'b0);
    check("stream_occ", 32'(occupancy), 32'd1);
    repeat (2) drive(1'b0, 3'd0, 3'd0, 6'h00, 1'b0);

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 3; i++) drive(1'b1, 3'd3, 3'(i + 4), 6'(i + 9), 1'b1);
    in_valid = 1'b0;
    wb_stall = 1'b0;
    rst      = 1'b0;
    #1;
    q.delete();
    wq.delete();
    check_outputs();
    #2;
    rst = 1'b1;
    repeat (2) drive(1'b0, 3'd0, 3'd0, 6'h00, 1'b0);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      qa_addr = 3'($urandom);
      qb_addr = 3'($urandom);
      drive(($urandom % 10) < 7, 3'($urandom), 3'($urandom % 4), 6'($urandom),
            ($urandom % 4) == 0);
    end
    repeat (DEPTH + 2) drive(1'b0, 3'd0, 3'd0, 6'h00, 1'b0);
    check("final_occ", 32'(occupancy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
